mmm_core: RTL and testbench

- Bit-serial radix-2 Montgomery modular multiplier for the RSA exponentiation datapath.
- Computes result = a·b·2^(-WIDTH) mod n.
- Sits downstream of the exponentiation control FSM, which sequences operands through it for each square and multiply step.
- Has its own start/busy/done handshake and honours the shared `en` clock-enable.

---
 rtl/mmm_core.sv | 114 +++++++++++
 tb/tb_mmm_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mmm_core.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^(-WIDTH) mod n.
// One iteration per enabled cycle, then a single conditional-subtract correction cycle.
module mmm_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH+1:0] s_q, s_d;
    logic [IW-1:0]    i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH+1:0] t_sum, u_sum, s_red;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_d      = b_q;
        n_d      = n_q;
        result_d = result_q;
        s_d      = s_q;
        i_d      = i_q;
        busy_d   = busy_q;
        done_d   = done_q;

        // Two guard bits on S keep S + B + N below 2^(WIDTH+2) for valid operands.
        t_sum = s_q + (a_sh_q[0] ? {2'b00, b_q} : '0);
        u_sum = t_sum + (t_sum[0] ? {2'b00, n_q} : '0);
        s_red = (s_q >= {2'b00, n_q}) ? (s_q - {2'b00, n_q}) : s_q;

        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    a_sh_d  = a;
                    b_d     = b;
                    n_d     = n;
                    s_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                s_d    = u_sum >> 1;
                a_sh_d = a_sh_q >> 1;
                i_d    = i_q + IW'(1);
                if (i_q == IW'(WIDTH - 1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                result_d = s_red[WIDTH-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            s_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (en) begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_q      <= b_d;
            n_q      <= n_d;
            result_q <= result_d;
            s_q      <= s_d;
            i_q      <= i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mmm_core.sv
// Self-checking bench for mmm_core: directed scenarios plus random odd moduli,
// compared against a brute-force modular-inverse reference.
module tb_mmm_core;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         start;
    logic [W-1:0] a, b, n;
    logic         busy, done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmm_core #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // The unique x in [0,n) with x * 2^W == a*b (mod n).
    function automatic logic [W-1:0] ref_mont(input int unsigned ra, input int unsigned rb,
                                              input int unsigned rn);
        int unsigned target;
        target = (ra * rb) % rn;
        for (int unsigned x = 0; x < rn; x++) begin
            if (((x << W) % rn) == target) return W'(x);
        end
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] tn);
        a     = ta;
        b     = tb_v;
        n     = tn;
        start = 1'b1;
    endtask

    // Called at the negedge where start is driven; returns at the negedge showing done.
    task automatic wait_done(input string tag, input logic [W-1:0] expv,
                             input int stall_at, input int inj_at);
        int          cyc;
        int          busy_cnt;
        int          extra;
        logic        sb, sd;
        logic [W-1:0] sr;
        extra    = (stall_at >= 0) ? 3 : 0;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            if (cyc == stall_at) begin
                en = 1'b0;
                sb = busy;
                sd = done;
                sr = result;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    cyc++;
                    if (busy === 1'b1) busy_cnt++;
                    chk({tag, "_stall_busy"}, 32'(busy), 32'(sb));
                    chk({tag, "_stall_done"}, 32'(done), 32'(sd));
                    chk({tag, "_stall_result"}, 32'(result), 32'(sr));
                end
                en = 1'b1;
            end
            if (cyc == inj_at) begin
                a     = 8'd9;
                b     = 8'd11;
                n     = 8'd13;
                start = 1'b1;
            end
            if (cyc == inj_at + 1) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(W + 2 + extra));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1 + extra));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'(0));
        chk({tag, "_result"}, 32'(result), 32'(expv));
    endtask

    initial begin
        int          seen_done;
        logic [W-1:0] rn, ra, rb;

        rst   = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        n     = 8'd1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_result", 32'(result), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // 5*7*2^-8 mod 13
        launch(8'd5, 8'd7, 8'd13);
        wait_done("basic", 8'd1, -1, -1);
        @(negedge clk);
        chk("basic_done_pulse", 32'(done), 32'(0));
        for (int k = 0; k < 3; k++) begin
            chk("basic_result_hold", 32'(result), 32'(1));
            @(negedge clk);
        end

        launch(8'd250, 8'd250, 8'd251);
        wait_done("big", 8'd201, -1, -1);
        launch(8'd1, 8'd1, 8'd13);
        wait_done("b2b", 8'd3, -1, -1);
        @(negedge clk);

        launch(8'd0, 8'd200, 8'd251);
        wait_done("zero_a", 8'd0, -1, -1);
        @(negedge clk);
        launch(8'd250, 8'd1, 8'd251);
        wait_done("b_one", 8'd50, -1, -1);
        @(negedge clk);

        launch(8'd5, 8'd7, 8'd13);
        wait_done("stall", 8'd1, 4, -1);
        @(negedge clk);

        launch(8'd5, 8'd7, 8'd13);
        wait_done("ign_start", 8'd1, -1, 2);
        @(negedge clk);
        chk("ign_start_no_retrigger", 32'(busy), 32'(0));

        launch(8'd5, 8'd7, 8'd13);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_result", 32'(result), 32'(0));
        seen_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        chk("midrst_no_done", 32'(seen_done), 32'(0));
        launch(8'd5, 8'd7, 8'd13);
        wait_done("after_rst", 8'd1, -1, -1);
        @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            rn = W'($urandom_range(1, 127) * 2 + 1);
            ra = W'($urandom_range(0, int'(rn) - 1));
            rb = W'($urandom_range(0, int'(rn) - 1));
            launch(ra, rb, rn);
            wait_done("rand", ref_mont(ra, rb, rn), -1, -1);
            if ((k % 3) == 0) @(negedge clk);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
